// File: rtl/pipe_ctrl.sv
// Pipeline control unit: drives stall/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB
// stage registers, and resolves bus freezes, load-use bubbles, branch redirects,
// MEM-stage exceptions, interrupts and exception return. Holds EPC, the latched
// exception code and the interrupt-enable flag.
module pipe_ctrl #(
    parameter int               ADDR_W     = 30,
    parameter int               EXP_W      = 3,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 30'h40,
    parameter logic [EXP_W-1:0]  EXP_INT    = 3'd1,
    parameter int               DRAIN_CYC  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ld_hazard,
    input  logic              id_br_taken,
    input  logic [ADDR_W-1:0] id_br_addr,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic [EXP_W-1:0]  mem_exp_code,
    input  logic              mem_eret,
    input  logic              int_detect,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic              pc_load,
    output logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] epc,
    output logic [EXP_W-1:0]  exp_code,
    output logic              int_en
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Value the drain counter takes on entry to DRAIN; reaching 0 returns to RUN.
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC - 1);

    state_t            state, state_next;
    logic [2:0]        drain_cnt, drain_cnt_next;
    logic [ADDR_W-1:0] epc_next;
    logic [EXP_W-1:0]  exp_code_next;
    logic              int_en_next;

    logic freeze;
    logic take_exc, take_int, take_eret;

    assign freeze    = if_busy | mem_busy;
    // Redirect events from MEM are only honoured in RUN and with a valid MEM instruction.
    assign take_exc  = (state == RUN) && mem_en && (mem_exp_code != '0);
    assign take_int  = (state == RUN) && mem_en && int_detect && int_en;
    assign take_eret = (state == RUN) && mem_en && mem_eret;

    // Stall/flush/redirect decode and next-state of the registered control.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        if_stall       = 1'b0;
        id_stall       = 1'b0;
        ex_stall       = 1'b0;
        mem_stall      = 1'b0;
        if_flush       = 1'b0;
        id_flush       = 1'b0;
        ex_flush       = 1'b0;
        mem_flush      = 1'b0;
        pc_load        = 1'b0;
        new_pc         = '0;
        state_next     = state;
        drain_cnt_next = drain_cnt;
        epc_next       = epc;
        exp_code_next  = exp_code;
        int_en_next    = int_en;

        if (reset) begin
            // Outputs stay at their all-zero defaults while reset is held.
        end else if (freeze) begin
            // A pending bus access holds every stage; registered state holds too.
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
        end else if (take_exc || take_int) begin
            if_flush       = 1'b1;
            id_flush       = 1'b1;
            ex_flush       = 1'b1;
            mem_flush      = 1'b1;
            pc_load        = 1'b1;
            new_pc         = EXC_VECTOR;
            epc_next       = mem_pc;
            exp_code_next  = take_exc ? mem_exp_code : EXP_INT;
            int_en_next    = 1'b0;
            state_next     = DRAIN;
            drain_cnt_next = DRAIN_LOAD;
        end else if (take_eret) begin
            if_flush       = 1'b1;
            id_flush       = 1'b1;
            ex_flush       = 1'b1;
            mem_flush      = 1'b1;
            pc_load        = 1'b1;
            new_pc         = epc;
            int_en_next    = 1'b1;
            state_next     = DRAIN;
            drain_cnt_next = DRAIN_LOAD;
        end else begin
            // Load-use beats a branch: the branch re-resolves once the bubble is in.
            if (ld_hazard) begin
                if_stall = 1'b1;
                id_flush = 1'b1;
            end else if (id_br_taken) begin
                if_flush = 1'b1;
                pc_load  = 1'b1;
                new_pc   = id_br_addr;
            end
            if (state == DRAIN) begin
                if (drain_cnt == 3'd0) begin
                    state_next = RUN;
                end else begin
                    drain_cnt_next = drain_cnt - 3'd1;
                end
            end
        end
    end

    // State, drain counter, EPC, exception code and interrupt enable registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state     <= RUN;
            drain_cnt <= 3'd0;
            epc       <= '0;
            exp_code  <= '0;
            int_en    <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            epc       <= epc_next;
            exp_code  <= exp_code_next;
            int_en    <= int_en_next;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expected values.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_busy, mem_busy, ld_hazard, id_br_taken;
    logic [29:0] id_br_addr;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic [2:0]  mem_exp_code;
    logic        mem_eret, int_detect;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic        pc_load;
    logic [29:0] new_pc, epc;
    logic [2:0]  exp_code;
    logic        int_en;

    int pass_cnt = 0;
    int total    = 0;

    // Combinational controls packed as {stalls IF..MEM, flushes IF..MEM, pc_load}.
    logic [8:0] ctl;
    assign ctl = {if_stall, id_stall, ex_stall, mem_stall,
                  if_flush, id_flush, ex_flush, mem_flush, pc_load};

    localparam logic [8:0] C_IDLE   = 9'b0000_0000_0;
    localparam logic [8:0] C_FREEZE = 9'b1111_0000_0;
    localparam logic [8:0] C_REDIR  = 9'b0000_1111_1;
    localparam logic [8:0] C_LDHAZ  = 9'b1000_0100_0;
    localparam logic [8:0] C_BRANCH = 9'b0000_1000_1;

    pipe_ctrl dut (
        .clk(clk), .reset(reset),
        .if_busy(if_busy), .mem_busy(mem_busy),
        .ld_hazard(ld_hazard), .id_br_taken(id_br_taken), .id_br_addr(id_br_addr),
        .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code),
        .mem_eret(mem_eret), .int_detect(int_detect),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .pc_load(pc_load), .new_pc(new_pc), .epc(epc), .exp_code(exp_code), .int_en(int_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-3 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        if_busy = 0; mem_busy = 0; ld_hazard = 0; id_br_taken = 0; id_br_addr = '0;
        mem_en = 0; mem_pc = '0; mem_exp_code = '0; mem_eret = 0; int_detect = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Reset held three cycles with random inputs: everything reads zero.
        for (int i = 0; i < 3; i++) begin
            step();
            if_busy = 1'($urandom); mem_busy = 1'($urandom); ld_hazard = 1'($urandom);
            id_br_taken = 1'($urandom); id_br_addr = 30'($urandom);
            mem_en = 1'($urandom); mem_pc = 30'($urandom); mem_exp_code = 3'($urandom);
            mem_eret = 1'($urandom); int_detect = 1'($urandom);
            settle();
            check("rst_ctl", 32'(ctl), 32'(C_IDLE));
            check("rst_new_pc", 32'(new_pc), 0);
            check("rst_epc", 32'(epc), 0);
            check("rst_int_en", 32'(int_en), 0);
            check("rst_exp_code", 32'(exp_code), 0);
        end
        step();
        idle_inputs();
        reset = 1'b0;
        settle();
        check("run_idle_ctl", 32'(ctl), 32'(C_IDLE));

        // Exception under a MEM freeze: hold everything, then redirect once busy drops.
        step();
        mem_busy = 1; mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h1000;
        settle();
        check("freeze_ctl", 32'(ctl), 32'(C_FREEZE));
        check("freeze_pc_load", 32'(pc_load), 0);
        step();
        check("freeze_epc_hold", 32'(epc), 0);
        mem_busy = 0;
        settle();
        check("exc_ctl", 32'(ctl), 32'(C_REDIR));
        check("exc_new_pc", 32'(new_pc), 32'h40);
        step();
        idle_inputs();
        check("exc_epc", 32'(epc), 32'h1000);
        check("exc_code", 32'(exp_code), 2);
        step();
        step();

        // Load-use and branch together: bubble first, branch on the next cycle.
        ld_hazard = 1; id_br_taken = 1; id_br_addr = 30'h2222;
        settle();
        check("ldbr_ctl", 32'(ctl), 32'(C_LDHAZ));
        check("ldbr_new_pc", 32'(new_pc), 0);
        step();
        ld_hazard = 0;
        settle();
        check("br_ctl", 32'(ctl), 32'(C_BRANCH));
        check("br_new_pc", 32'(new_pc), 32'h2222);
        step();
        idle_inputs();

        // Exception at 0x123 to seed EPC, drain, then eret.
        mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h123;
        step();
        idle_inputs();
        check("seed_epc", 32'(epc), 32'h123);
        step();
        step();
        mem_en = 1; mem_eret = 1;
        settle();
        check("eret_ctl", 32'(ctl), 32'(C_REDIR));
        check("eret_new_pc", 32'(new_pc), 32'h123);
        step();
        check("eret_int_en", 32'(int_en), 1);
        check("eret_code_hold", 32'(exp_code), 3);
        // Interrupt pending through both DRAIN cycles, accepted on the third.
        mem_eret = 0; int_detect = 1; mem_pc = 30'h555;
        settle();
        check("drain1_ctl", 32'(ctl), 32'(C_IDLE));
        step();
        settle();
        check("drain2_ctl", 32'(ctl), 32'(C_IDLE));
        step();
        settle();
        check("int_ctl", 32'(ctl), 32'(C_REDIR));
        check("int_new_pc", 32'(new_pc), 32'h40);
        step();
        idle_inputs();
        check("int_code", 32'(exp_code), 1);
        check("int_epc", 32'(epc), 32'h555);
        check("int_en_clr", 32'(int_en), 0);
        step();
        step();

        // With int_en=0 a pending interrupt is ignored; mem_en=0 masks exc/eret.
        mem_en = 1; int_detect = 1;
        settle();
        check("int_masked_ctl", 32'(ctl), 32'(C_IDLE));
        mem_en = 0; int_detect = 0; mem_exp_code = 3'd6; mem_eret = 1;
        settle();
        check("mem_en0_ctl", 32'(ctl), 32'(C_IDLE));
        step();
        check("mem_en0_code", 32'(exp_code), 1);
        // Re-enable interrupts via eret, drain, then exc and int together.
        idle_inputs();
        mem_en = 1; mem_eret = 1;
        step();
        idle_inputs();
        step();
        step();
        check("reenable_int_en", 32'(int_en), 1);
        mem_en = 1; int_detect = 1; mem_exp_code = 3'd5; mem_pc = 30'h777;
        settle();
        check("excint_ctl", 32'(ctl), 32'(C_REDIR));
        step();
        idle_inputs();
        check("excint_code", 32'(exp_code), 5);
        check("excint_epc", 32'(epc), 32'h777);

        // Reset while in DRAIN: back to RUN, next exception accepted at once.
        reset = 1;
        step();
        reset = 0;
        check("rst2_epc", 32'(epc), 0);
        check("rst2_int_en", 32'(int_en), 0);
        mem_en = 1; mem_exp_code = 3'd4; mem_pc = 30'h99;
        settle();
        check("post_rst_ctl", 32'(ctl), 32'(C_REDIR));
        check("post_rst_new_pc", 32'(new_pc), 32'h40);
        step();
        idle_inputs();
        check("post_rst_code", 32'(exp_code), 4);
        check("post_rst_epc", 32'(epc), 32'h99);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
